// File: rtl/wishbone_scheduler_pkg.sv
// Shared types and constants for the three-port Wishbone L2 scheduler.
package wishbone_scheduler_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADR_W     = 32;
    localparam int DATA_W    = 32;
    localparam int SEL_W     = DATA_W / 8;

    typedef logic [1:0] port_idx_t;

    localparam port_idx_t PORT_I     = 2'd0;
    localparam port_idx_t PORT_D     = 2'd1;
    localparam port_idx_t PORT_PF    = 2'd2;
    localparam port_idx_t GRANT_NONE = 2'd3;

    typedef enum logic {IDLE, BUSY} sched_state_t;

endpackage

// File: rtl/wishbone_scheduler_if.sv
// Classic Wishbone bus bundle; master drives the request, slave returns ACK/DAT_S.
interface wishbone;
    import wishbone_scheduler_pkg::*;

    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] dat_m;
    logic [DATA_W-1:0] dat_s;
    logic [SEL_W-1:0]  sel;
    logic              cyc;
    logic              stb;
    logic              we;
    logic              ack;

    modport master (output adr, dat_m, sel, cyc, stb, we, input dat_s, ack);
    modport slave  (input adr, dat_m, sel, cyc, stb, we, output dat_s, ack);

endinterface

// File: rtl/wishbone_scheduler_aging_priority_picker.sv
// Combinational winner select: starved requesters first, each tier ordered d-cache > i-cache > prefetcher.
module aging_priority_picker
    import wishbone_scheduler_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] starved,
    output port_idx_t            winner,
    output logic                 any_req
);

    logic [NUM_PORTS-1:0] cand;

    always_comb begin
        cand    = (|(req & starved)) ? (req & starved) : req;
        any_req = |req;
        winner  = GRANT_NONE;
        if (cand[PORT_D])
            winner = PORT_D;
        else if (cand[PORT_I])
            winner = PORT_I;
        else if (cand[PORT_PF])
            winner = PORT_PF;
    end

endmodule

// File: rtl/wishbone_scheduler.sv
// Three-port Wishbone L2 scheduler: fixed priority with aging, one locked transaction in flight.
// Optional per-port grant/wait counters under `WISHBONE_SCHEDULER_PERF_EN.
module wishbone_scheduler
    import wishbone_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    wishbone.slave    input_wishbone0,
    wishbone.slave    input_wishbone1,
    wishbone.slave    input_wishbone2,
    wishbone.master   output_wishbone,
    output port_idx_t debug_grant
`ifdef WISHBONE_SCHEDULER_PERF_EN
    ,
    output logic [31:0] perf_grants0,
    output logic [31:0] perf_grants1,
    output logic [31:0] perf_grants2,
    output logic [31:0] perf_wait0,
    output logic [31:0] perf_wait1,
    output logic [31:0] perf_wait2
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    sched_state_t         state;
    port_idx_t            grant;
    logic [CNT_W-1:0]     wait_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] cyc, stb, we, req, starved, wait_inc, ack_route;
    logic [ADR_W-1:0]     adr [NUM_PORTS];
    logic [DATA_W-1:0]    dat_m [NUM_PORTS];
    logic [DATA_W-1:0]    dat_s_route [NUM_PORTS];
    logic [SEL_W-1:0]     sel [NUM_PORTS];

    logic                 fwd_cyc, fwd_stb, fwd_we, grant_cyc, any_req;
    logic [ADR_W-1:0]     fwd_adr;
    logic [DATA_W-1:0]    fwd_dat_m;
    logic [SEL_W-1:0]     fwd_sel;
    port_idx_t            winner;

    assign cyc[0] = input_wishbone0.cyc;   assign stb[0] = input_wishbone0.stb;
    assign we[0]  = input_wishbone0.we;    assign adr[0] = input_wishbone0.adr;
    assign sel[0] = input_wishbone0.sel;   assign dat_m[0] = input_wishbone0.dat_m;
    assign cyc[1] = input_wishbone1.cyc;   assign stb[1] = input_wishbone1.stb;
    assign we[1]  = input_wishbone1.we;    assign adr[1] = input_wishbone1.adr;
    assign sel[1] = input_wishbone1.sel;   assign dat_m[1] = input_wishbone1.dat_m;
    assign cyc[2] = input_wishbone2.cyc;   assign stb[2] = input_wishbone2.stb;
    assign we[2]  = input_wishbone2.we;    assign adr[2] = input_wishbone2.adr;
    assign sel[2] = input_wishbone2.sel;   assign dat_m[2] = input_wishbone2.dat_m;

    assign input_wishbone0.ack   = ack_route[0];
    assign input_wishbone1.ack   = ack_route[1];
    assign input_wishbone2.ack   = ack_route[2];
    assign input_wishbone0.dat_s = dat_s_route[0];
    assign input_wishbone1.dat_s = dat_s_route[1];
    assign input_wishbone2.dat_s = dat_s_route[2];

    assign output_wishbone.cyc   = fwd_cyc;
    assign output_wishbone.stb   = fwd_stb;
    assign output_wishbone.we    = fwd_we;
    assign output_wishbone.adr   = fwd_adr;
    assign output_wishbone.dat_m = fwd_dat_m;
    assign output_wishbone.sel   = fwd_sel;

    assign req         = cyc & stb;
    assign debug_grant = grant;

    aging_priority_picker u_picker (
        .req     (req),
        .starved (starved),
        .winner  (winner),
        .any_req (any_req)
    );

    // The granted port is wired straight through so an abort drops CYC in the same cycle.
    always_comb begin
        fwd_cyc     = 1'b0;
        fwd_stb     = 1'b0;
        fwd_we      = 1'b0;
        fwd_adr     = '0;
        fwd_dat_m   = '0;
        fwd_sel     = '0;
        grant_cyc   = 1'b0;
        ack_route   = '0;
        dat_s_route = '{default: '0};
        for (int p = 0; p < NUM_PORTS; p++) begin
            starved[p]  = (wait_cnt[p] == CNT_W'(STARVE_LIMIT));
            wait_inc[p] = req[p] && ((state == IDLE) ? (winner != port_idx_t'(p))
                                                     : (grant != port_idx_t'(p)));
            if (state == BUSY && grant == port_idx_t'(p)) begin
                grant_cyc      = cyc[p];
                fwd_cyc        = cyc[p];
                fwd_stb        = stb[p];
                fwd_we         = we[p];
                fwd_adr        = adr[p];
                fwd_dat_m      = dat_m[p];
                fwd_sel        = sel[p];
                ack_route[p]   = cyc[p] & output_wishbone.ack & ~rst;
                dat_s_route[p] = output_wishbone.dat_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= GRANT_NONE;
            for (int p = 0; p < NUM_PORTS; p++)
                wait_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!wait_inc[p])
                    wait_cnt[p] <= '0;
                else if (!starved[p])
                    wait_cnt[p] <= wait_cnt[p] + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= BUSY;
                        grant <= winner;
                    end
                end
                BUSY: begin
                    if (output_wishbone.ack || !grant_cyc) begin
                        state <= IDLE;
                        grant <= GRANT_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= GRANT_NONE;
                end
            endcase
        end
    end

`ifdef WISHBONE_SCHEDULER_PERF_EN
    logic [31:0] perf_g [NUM_PORTS];
    logic [31:0] perf_w [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                perf_g[p] <= '0;
                perf_w[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (state == IDLE && any_req && winner == port_idx_t'(p))
                    perf_g[p] <= perf_g[p] + 32'd1;
                if (wait_inc[p])
                    perf_w[p] <= perf_w[p] + 32'd1;
            end
        end
    end

    assign perf_grants0 = perf_g[0];
    assign perf_grants1 = perf_g[1];
    assign perf_grants2 = perf_g[2];
    assign perf_wait0   = perf_w[0];
    assign perf_wait1   = perf_w[1];
    assign perf_wait2   = perf_w[2];
`endif

endmodule

// File: doc/wishbone_scheduler.md
Name: wishbone_scheduler

Overview:
- Shares the L2 cache slave port between three line-granularity requesters: port0 = i-cache, port1 = d-cache, port2 = line prefetcher.
- Sits between the L1 caches/prefetcher and the barrier stage in front of the L2.
- Uses fixed priority with per-port aging for anti-starvation.
- Holds one transaction in flight and locks the grant until the L2 ACKs or the requester aborts.

Parameters:
- STARVE_LIMIT, 16: wait cycles after which a requesting port is forced to win the next arbitration; must be ≥ 1.
- NUM_PORTS, 3: number of requester ports; fixed at 3 in this revision, present for package sizing only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- input_wishbone0  wishbone.slave  interface  i-cache requester (ADR, DAT_M, DAT_S, SEL, CYC, STB, WE, ACK).
- input_wishbone1  wishbone.slave  interface  d-cache requester.
- input_wishbone2  wishbone.slave  interface  prefetcher requester.
- output_wishbone  wishbone.master  interface  toward the L2 barrier.
- debug_grant  output  2  granted port index, valid while busy; 3 = none.

Behaviour:
- Request: port p requests when CYC & STB. Requesters hold ADR/DAT_M/SEL/WE stable until they see ACK (classic Wishbone).
- State machine:
  - IDLE: if any port requests, pick a winner, register it into grant, go to BUSY.
  - BUSY: forward granted port ADR/DAT_M/SEL/WE/CYC/STB combinationally to output. Route output ACK and DAT_S to the granted port only; all other ports get ACK = 0.
  - Output ACK = 1 in BUSY: return to IDLE the same edge.
  - Granted port drops CYC in BUSY (abort): output CYC/STB fall the same cycle, go to IDLE, and drop any ACK that arrives that cycle.
- Latency and throughput:
  - Request seen in cycle n gives output STB in cycle n+1.
  - One mandatory IDLE cycle between transactions, so no back-to-back grants.
- Arbitration order:
  - Any starved port (wait_cnt == STARVE_LIMIT) wins, ties resolved 1 > 0 > 2.
  - Otherwise fixed priority 1 > 0 > 2.
- wait_cnt[p]:
  - Increments each cycle port p requests and is not the granted port in BUSY, or loses arbitration in IDLE.
  - Saturates at STARVE_LIMIT.
  - Clears when p is granted or p is not requesting.
- Simultaneous events:
  - ACK and new requests in the same cycle: the new requests arbitrate in the following IDLE cycle.
  - A request arriving while BUSY waits.
- Reset values:
  - state = IDLE, all wait_cnt = 0, debug_grant = 3.
  - Output CYC/STB/WE = 0, ADR/DAT_M/SEL = 0.
  - All input ACKs = 0.
- Reset asserted in BUSY: the transaction is abandoned, output CYC drops the next cycle, and no ACK is forwarded.
- Idle outputs: in IDLE, output CYC/STB = 0 and data/address are driven 0.

Optional Feature:
- Macro: WISHBONE_SCHEDULER_PERF_EN.
- Defined:
  - Adds outputs perf_grants0..2 (32 bit) counting grants per port.
  - Adds outputs perf_wait0..2 (32 bit) counting cycles each port waited.
  - All counters wrap, clear on rst, and are incremented on the same edges as grant/wait_cnt.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package wishbone_scheduler_pkg holds:
  - NUM_PORTS;
  - port index constants PORT_I = 0, PORT_D = 1, PORT_PF = 2, GRANT_NONE = 3;
  - typedef sched_state_t {IDLE, BUSY};
  - typedef port_idx_t (logic [1:0]).
- Sub-module aging_priority_picker: combinational winner selection from the request vector plus the starved vector. Aging counters stay in the top module.

Test Plan:
- Single request: port0 reads ADR 0x0000040, ACK returned 3 cycles later → output STB rises 1 cycle after the request, port0 ACK coincides with output ACK, then IDLE for 1 cycle.
- Simultaneous requests from ports 0, 1 and 2 → grants in order 1, 0, 2. Each grant follows an IDLE cycle. debug_grant shows 1, 3, 0, 3, 2.
- Starvation: port1 requests continuously, port2 requests continuously, STARVE_LIMIT = 4 → port2 is granted by its 4th arbitration at the latest, and its wait_cnt is 0 after the grant.
- Abort: port0 granted, drops CYC before ACK; L2 ACKs in the same cycle → output CYC low that cycle, port0 gets no ACK, next grant goes to the pending port.
- Reset mid-transaction: rst asserted in BUSY for 1 cycle → output CYC = 0 after the edge, debug_grant = 3, no ACK reaches any port.
- With WISHBONE_SCHEDULER_PERF_EN: 5 port1 grants and 2 port0 grants → perf_grants1 = 5, perf_grants0 = 2, perf_grants2 = 0.
